// File: rtl/mm_seq.sv
// Request sequencer for the Montgomery multiplier core: runs MM(a,b) then MM(t,R^2 mod p)
// so the host sees a plain a*b mod p, with a timeout guard on each core run.
//
// state  | meaning
// IDLE   | waiting for a request, core held in reset
// P1_RST | core reset low, operands a, b presented
// P1_RUN | core running MM(a,b)
// P2_RST | core reset low, operands t, r2 presented
// P2_RUN | core running MM(t,r2)
// RESP   | result held until the consumer takes it
module mm_seq #(
  parameter int W       = 256,
  parameter int MPW     = 32,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  input  logic [W-1:0]   cfg_p,
  input  logic [MPW-1:0] cfg_pp,
  input  logic [W-1:0]   cfg_r2,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_z,
  output logic           rsp_err,
  output logic           busy,
  output logic [W-1:0]   mm_multiplier,
  output logic [W-1:0]   mm_multiplicand,
  output logic [W-1:0]   mm_modulus,
  output logic [MPW-1:0] mm_mp,
  output logic           mm_rstn,
  input  logic [W-1:0]   mm_result,
  input  logic           mm_end_flag
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [2:0] {IDLE, P1_RST, P1_RUN, P2_RST, P2_RUN, RESP} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_q, b_q, p_q, r2_q, t_q, z_q;
  logic [MPW-1:0] pp_q;
  logic           err_q;
  logic           live_q;
  logic [RW-1:0]  rst_cnt;
  logic [CW-1:0]  run_cnt;
  logic           rst_done;
  logic           run_to;
  logic           accept;

  assign rst_done = (rst_cnt == '0);
  // the check fires in the TIMEOUT-th run cycle, counter holds cycles already elapsed
  assign run_to   = (run_cnt == CW'(TIMEOUT - 1));
  assign accept   = (state == IDLE) && live_q && req_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = P1_RST;
      P1_RST: if (rst_done) state_nxt = P1_RUN;
      P1_RUN: if (mm_end_flag) state_nxt = P2_RST;
              else if (run_to) state_nxt = RESP;
      P2_RST: if (rst_done) state_nxt = P2_RUN;
      P2_RUN: if (mm_end_flag || run_to) state_nxt = RESP;
      RESP:   if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      live_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      pp_q    <= '0;
      r2_q    <= '0;
      t_q     <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
      rst_cnt <= '0;
      run_cnt <= '0;
    end else begin
      live_q <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          a_q     <= req_a;
          b_q     <= req_b;
          p_q     <= cfg_p;
          pp_q    <= cfg_pp;
          r2_q    <= cfg_r2;
          z_q     <= '0;
          err_q   <= 1'b0;
          rst_cnt <= RW'(RST_CYC - 1);
        end
        P1_RST, P2_RST: begin
          run_cnt <= '0;
          if (!rst_done) rst_cnt <= rst_cnt - 1'b1;
        end
        P1_RUN: begin
          if (mm_end_flag) begin
            t_q     <= mm_result;
            rst_cnt <= RW'(RST_CYC - 1);
          end else if (run_to) begin
            err_q <= 1'b1;
            z_q   <= '0;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        P2_RUN: begin
          if (mm_end_flag) begin
            z_q <= mm_result;
          end else if (run_to) begin
            err_q <= 1'b1;
            z_q   <= '0;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready       = live_q && (state == IDLE);
    busy            = (state != IDLE);
    rsp_valid       = (state == RESP);
    rsp_z           = z_q;
    rsp_err         = err_q;
    mm_rstn         = (state == P1_RUN) || (state == P2_RUN);
    mm_modulus      = p_q;
    mm_mp           = pp_q;
    mm_multiplier   = '0;
    mm_multiplicand = '0;
    case (state)
      P1_RST, P1_RUN: begin
        mm_multiplier   = a_q;
        mm_multiplicand = b_q;
      end
      P2_RST, P2_RUN: begin
        mm_multiplier   = t_q;
        mm_multiplicand = r2_q;
      end
      default: ;
    endcase
  end

endmodule
